// File: rtl/branch_resolve_ctrl_if.sv
// Op/result bundle for the execute-stage branch resolver.
// master drives ops (decode side); slave is the resolver.
interface branch_resolve_ctrl_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic            out_valid;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic [XLEN-1:0] out_link;
  logic            out_illegal;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
  logic            stat_clr;

  modport master (
    output in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm,
           in_pred_taken, stat_clr,
    input  in_ready, out_valid, out_taken, out_target, out_link, out_illegal,
           redirect, redirect_pc, flush, stat_branches, stat_mispredicts
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm,
           in_pred_taken, stat_clr,
    output in_ready, out_valid, out_taken, out_target, out_link, out_illegal,
           redirect, redirect_pc, flush, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// RV32I execute-stage branch/jump resolver with mispredict redirect and timed flush.
// Optional resolved/mispredict counters are built only when BR_STATS_EN is defined.
//
// state | meaning
// RUN   | accepting one op per cycle
// FLUSH | mispredict flush in progress, ops held off
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  branch_resolve_ctrl_if.slave         bus
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            out_valid_q;
  logic            out_taken_q;
  logic [XLEN-1:0] out_target_q;
  logic [XLEN-1:0] out_link_q;
  logic            out_illegal_q;
  logic            redirect_q;
  logic [XLEN-1:0] redirect_pc_q;

  logic            in_ready;
  logic            flush;
  logic            accept;
  logic            br_eq, br_lt, br_ltu;
  logic            cond;
  logic            illegal;
  logic            taken;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic            mispredict;

  // Branch_CondGen-style comparator flags
  assign br_eq  = (bus.in_rs1 == bus.in_rs2);
  assign br_lt  = ($signed(bus.in_rs1) < $signed(bus.in_rs2));
  assign br_ltu = (bus.in_rs1 < bus.in_rs2);

  assign accept   = bus.in_valid && in_ready;
  assign pc_plus4 = bus.in_pc + XLEN'(4);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    taken   = 1'b0;
    target  = pc_plus4;

    case (bus.in_funct3[2:1])
      2'b00:   cond = br_eq  ^ bus.in_funct3[0];
      2'b10:   cond = br_lt  ^ bus.in_funct3[0];
      2'b11:   cond = br_ltu ^ bus.in_funct3[0];
      default: cond = 1'b0;
    endcase

    case (bus.in_kind)
      2'b00: begin
        if (bus.in_funct3[2:1] == 2'b01) begin
          illegal = 1'b1;
        end else begin
          taken  = cond;
          target = cond ? (bus.in_pc + bus.in_imm) : pc_plus4;
        end
      end
      2'b01: begin
        taken  = 1'b1;
        target = bus.in_pc + bus.in_imm;
      end
      2'b10: begin
        taken  = 1'b1;
        target = (bus.in_rs1 + bus.in_imm) & ~XLEN'(1);
      end
      default: illegal = 1'b1;
    endcase
  end

  assign mispredict = accept && !illegal && (taken != bus.in_pred_taken);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d = ST_FLUSH;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = 1'b0;
    flush    = 1'b0;
    case (state_q)
      ST_RUN:   in_ready = 1'b1;
      ST_FLUSH: flush    = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_target_q  <= '0;
      out_link_q    <= '0;
      out_illegal_q <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      out_valid_q <= accept;
      redirect_q  <= mispredict;
      if (accept) begin
        out_taken_q   <= taken;
        out_target_q  <= target;
        out_link_q    <= pc_plus4;
        out_illegal_q <= illegal;
      end
      if (mispredict) redirect_pc_q <= target;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.flush       = flush;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_taken   = out_taken_q;
  assign bus.out_target  = out_target_q;
  assign bus.out_link    = out_link_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

`ifdef BR_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  // Clear wins over a same-cycle increment; both counters saturate.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (bus.stat_clr) begin
      stat_br_d = '0;
      stat_mp_d = '0;
    end else begin
      if (accept && !illegal && (stat_br_q != '1)) stat_br_d = stat_br_q + 32'd1;
      if (mispredict && (stat_mp_q != '1))         stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr      = bus.stat_clr;
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule
